// File: rtl/accum_adder.sv
// accum_adder: multi-channel frame accumulator.
// Each channel sums unsigned beats until a beat marked last arrives. That
// beat's total, and whether any partial sum overflowed, are loaded into a
// single output register held under a valid/ready handshake.
module accum_adder #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int NUM_CH    = 4,
  parameter int SATURATE  = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [CH_W-1:0]      din_ch,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [CH_W-1:0]      dout_ch,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_ovf
);

  // The accumulator table is sized to the full index range so that any
  // din_ch value reads a defined entry; entries at or above NUM_CH are
  // never written and stay zero.
  localparam int ACC_N = 1 << CH_W;

  logic [ACC_WIDTH-1:0] acc [ACC_N];
  logic [ACC_N-1:0]     ovf;

  logic [CH_W-1:0]      ch_idx;
  logic                 ch_ok;
  logic [ACC_WIDTH:0]   sum;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] result;
  logic                 accept;
  logic                 accept_last;

  // Overflow handling: wrap keeps the low bits, saturate clamps to all-ones.
  function automatic logic [ACC_WIDTH-1:0] clamp(input logic [ACC_WIDTH:0] s);
    if ((SATURATE != 0) && s[ACC_WIDTH])
      clamp = '1;
    else
      clamp = s[ACC_WIDTH-1:0];
  endfunction

  // A single channel ignores din_ch; otherwise out-of-range indices are
  // accepted on the handshake but change no state.
  generate
    if (NUM_CH == 1) begin : g_single
      assign ch_idx = '0;
      assign ch_ok  = 1'b1;
    end else begin : g_multi
      assign ch_idx = din_ch;
      assign ch_ok  = ({1'b0, din_ch} < (CH_W + 1)'(NUM_CH));
    end
  endgenerate

  // Input side: a beat may enter whenever clear is low and the output
  // register is free or being drained this cycle.
  assign din_ready   = ~clear & (~dout_valid | dout_ready);
  assign accept      = din_valid & din_ready & ch_ok;
  assign accept_last = accept & din_last;

  assign sum     = {1'b0, acc[ch_idx]} + (ACC_WIDTH + 1)'(din);
  assign sum_ovf = sum[ACC_WIDTH];
  assign result  = clamp(sum);

  // Per-channel running sums and sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ACC_N; i++) acc[i] <= '0;
      ovf <= '0;
    end else if (clear) begin
      for (int i = 0; i < ACC_N; i++) acc[i] <= '0;
      ovf <= '0;
    end else if (accept) begin
      if (din_last) begin
        acc[ch_idx] <= '0;
        ovf[ch_idx] <= 1'b0;
      end else begin
        acc[ch_idx] <= result;
        ovf[ch_idx] <= ovf[ch_idx] | sum_ovf;
      end
    end
  end

  // Output register: loads a finished frame, holds it until taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_ovf   <= 1'b0;
    end else if (accept_last) begin
      dout_valid <= 1'b1;
      dout       <= result;
      dout_ch    <= ch_idx;
      dout_ovf   <= ovf[ch_idx] | sum_ovf;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accum_adder.sv
// tb_accum_adder: three accum_adder instances driven by the same stimulus
// (wrap / 4 channels, saturate / 4 channels, wrap / 3 channels) are compared
// every cycle against a frame-level model, with directed scenarios carrying
// hand-computed expectations followed by a randomized run.
module tb_accum_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic din_valid = 1'b0;
  logic [1:0] din_ch = '0;
  logic [7:0] din = '0;
  logic din_last = 1'b0;
  logic dout_ready = 1'b1;

  logic [2:0]       dr;
  logic [2:0]       dv;
  logic [2:0][1:0]  dc;
  logic [2:0][9:0]  dq;
  logic [2:0]       dov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accum_adder #(.WIDTH(8), .ACC_WIDTH(10), .NUM_CH(4), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din_valid(din_valid), .din_ready(dr[0]),
    .din_ch(din_ch), .din(din), .din_last(din_last), .dout_valid(dv[0]),
    .dout_ready(dout_ready), .dout_ch(dc[0]), .dout(dq[0]), .dout_ovf(dov[0]));

  accum_adder #(.WIDTH(8), .ACC_WIDTH(10), .NUM_CH(4), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din_valid(din_valid), .din_ready(dr[1]),
    .din_ch(din_ch), .din(din), .din_last(din_last), .dout_valid(dv[1]),
    .dout_ready(dout_ready), .dout_ch(dc[1]), .dout(dq[1]), .dout_ovf(dov[1]));

  accum_adder #(.WIDTH(8), .ACC_WIDTH(10), .NUM_CH(3), .SATURATE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din_valid(din_valid), .din_ready(dr[2]),
    .din_ch(din_ch), .din(din), .din_last(din_last), .dout_valid(dv[2]),
    .dout_ready(dout_ready), .dout_ch(dc[2]), .dout(dq[2]), .dout_ovf(dov[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_acc  [3][4];
  bit  m_ovf  [3][4];
  bit  m_valid[3];
  int  m_dout [3];
  int  m_ch   [3];
  bit  m_ovfo [3];

  function automatic int nch(input int s);
    return (s == 2) ? 3 : 4;
  endfunction

  function automatic bit sat(input int s);
    return (s == 1);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        m_acc[s][c] = 0;
        m_ovf[s][c] = 0;
      end
      m_valid[s] = 0;
      m_dout[s]  = 0;
      m_ch[s]    = 0;
      m_ovfo[s]  = 0;
    end
  endtask

  task automatic model_step(input int s);
    bit rdy, drop, o;
    int total, v, c;
    rdy  = !clear && (!m_valid[s] || dout_ready);
    drop = m_valid[s] && dout_ready;
    c    = int'(din_ch);
    if (clear) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[s][k] = 0;
        m_ovf[s][k] = 0;
      end
    end else if (din_valid && rdy && c < nch(s)) begin
      total = m_acc[s][c] + int'(din);
      o = (total > 1023);
      if (sat(s)) v = o ? 1023 : total;
      else        v = total % 1024;
      if (din_last) begin
        m_dout[s]  = v;
        m_ch[s]    = c;
        m_ovfo[s]  = m_ovf[s][c] | o;
        m_valid[s] = 1;
        drop       = 0;
        m_acc[s][c] = 0;
        m_ovf[s][c] = 0;
      end else begin
        m_acc[s][c] = v;
        m_ovf[s][c] = m_ovf[s][c] | o;
      end
    end
    if (drop) m_valid[s] = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int s = 0; s < 3; s++) model_step(s);
    end
  end

  // Compare every DUT against the model on each falling edge.
  initial begin
    @(negedge clk);
    forever begin
      for (int s = 0; s < 3; s++) begin
        chk($sformatf("dout_valid[%0d]", s), dv[s], m_valid[s]);
        chk($sformatf("din_ready[%0d]", s), dr[s],
            (!clear && (!m_valid[s] || dout_ready)) ? 1 : 0);
        if (m_valid[s]) begin
          chk($sformatf("dout[%0d]", s), dq[s], m_dout[s]);
          chk($sformatf("dout_ch[%0d]", s), dc[s], m_ch[s]);
          chk($sformatf("dout_ovf[%0d]", s), dov[s], m_ovfo[s]);
        end
      end
      @(negedge clk);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic beat(input int ch, input int val, input bit last);
    bit done = 0;
    din_valid = 1'b1;
    din_ch    = ch[1:0];
    din       = val[7:0];
    din_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (dr[0]) done = 1;
      tick();
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL beat_timeout: ch %0d value %0d never accepted, expected acceptance", ch, val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    tick();
    chk("reset_dout_valid", dv[0], 0);
    chk("reset_dout", dq[0], 0);
    chk("reset_dout_ovf", dov[0], 0);
    rst_n = 1'b1;
    #1;
    chk("release_din_ready", dr[0], 1);

    // three beats on ch0
    beat(0, 10, 0); beat(0, 20, 0); beat(0, 30, 1);
    chk("sum60_valid", dv[0], 1);
    chk("sum60_dout", dq[0], 60);
    chk("sum60_ch", dc[0], 0);
    chk("sum60_ovf", dov[0], 0);
    chk("model_sum60", m_dout[0], 60);
    tick();
    chk("sum60_one_cycle", dv[0], 0);

    // interleaved channels
    beat(1, 5, 0); beat(2, 7, 0); beat(1, 3, 1);
    chk("ilv_ch1_dout", dq[0], 8);
    chk("ilv_ch1_ch", dc[0], 1);
    beat(2, 1, 1);
    chk("ilv_ch2_dout", dq[0], 8);
    chk("ilv_ch2_ch", dc[0], 2);
    chk("ilv_ch2_ovf", dov[0], 0);

    // overflow on ch3: wrap vs saturate; ch3 discarded by the 3-channel unit
    for (int i = 0; i < 4; i++) beat(3, 255, 0);
    beat(3, 255, 1);
    chk("wrap_dout", dq[0], 251);
    chk("wrap_ovf", dov[0], 1);
    chk("sat_dout", dq[1], 1023);
    chk("sat_ovf", dov[1], 1);
    chk("model_sat", m_dout[1], 1023);
    chk("oob_no_output", dv[2], 0);
    beat(3, 1, 1);
    chk("after_ovf_dout", dq[0], 1);
    chk("after_ovf_flag", dov[0], 0);
    chk("after_ovf_sat_dout", dq[1], 1);
    tick();

    // backpressure
    dout_ready = 1'b0;
    beat(0, 4, 1);
    din_valid = 1'b1; din_ch = 2'd1; din = 8'd9; din_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_din_ready", dr[0], 0);
      chk("bp_dout_stable", dq[0], 4);
      chk("bp_valid_held", dv[0], 1);
      tick();
    end
    dout_ready = 1'b1;
    #1;
    chk("bp_release_ready", dr[0], 1);
    tick();
    din_valid = 1'b0; din_last = 1'b0;
    chk("bp_next_valid", dv[0], 1);
    chk("bp_next_dout", dq[0], 9);
    chk("bp_next_ch", dc[0], 1);
    tick();

    // clear
    beat(0, 100, 0);
    clear = 1'b1;
    din_valid = 1'b1; din_ch = 2'd0; din = 8'd77; din_last = 1'b1;
    #1;
    chk("clear_din_ready", dr[0], 0);
    tick();
    clear = 1'b0; din_valid = 1'b0; din_last = 1'b0;
    chk("clear_no_output", dv[0], 0);
    beat(0, 1, 1);
    chk("after_clear_dout", dq[0], 1);
    tick();

    // asynchronous reset mid-cycle with a result pending
    beat(0, 50, 0);
    dout_ready = 1'b0;
    beat(1, 7, 1);
    chk("pre_reset_valid", dv[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", dv[0], 0);
    chk("async_reset_dout", dq[0], 0);
    tick();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    beat(0, 2, 1);
    chk("after_reset_dout", dq[0], 2);
    chk("after_reset_ovf", dov[0], 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      din_valid  = ($urandom_range(0, 3) != 0);
      din_ch     = 2'($urandom_range(0, 3));
      din        = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(200, 255))
                                               : 8'($urandom_range(0, 255));
      din_last   = ($urandom_range(0, 3) == 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      clear      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end
    din_valid = 1'b0; clear = 1'b0; dout_ready = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
